// File: rtl/ahb_sram_wbuf_pkg.sv
// Shared types for the AHB-Lite posted-write buffer in front of the SRAM controller.
// Entry fields are sized for address/data widths up to 32 bits.
package ahb_sram_wbuf_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned ENT_ADDR_W = 32;
    localparam int unsigned ENT_DATA_W = 32;
    localparam logic [2:0]  HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_D,
        ST_RD_A,
        ST_RD_D
    } state_e;

    typedef struct packed {
        logic [ENT_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [ENT_DATA_W-1:0] data;
    } entry_t;

    function automatic logic is_full_word(input logic [2:0] size);
        return size == HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf_fifo.sv
// Posted-write FIFO: synchronous, registered count, head always visible.
module ahb_sram_wbuf_fifo
    import ahb_sram_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ahb_sram_wbuf.sv
// AHB-Lite write buffer: posts upstream writes, drains them in order to the SRAM port.
// Optional AHB_SRAM_WBUF_RAW_FWD_EN: forward a full-word read hit on the youngest buffered write.
module ahb_sram_wbuf
    import ahb_sram_wbuf_pkg::*;
#(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,

    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,

    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic [W_DATA-1:0] ahblm_hrdata
);

    state_e              state_q, state_d;
    logic                dph_wr_q, dph_wr_d;
    logic                dph_rd_q, dph_rd_d;
    logic [W_ADDR-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [W_ADDR-1:0]   m_haddr_q, m_haddr_d;
    logic                m_hwrite_q, m_hwrite_d;
    logic [1:0]          m_htrans_q, m_htrans_d;
    logic [2:0]          m_hsize_q, m_hsize_d;
    logic [W_DATA-1:0]   m_hwdata_q, m_hwdata_d;

    logic                aph_valid;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    entry_t              push_entry;
    entry_t              head;
    logic                fwd_hit;
    logic [W_DATA-1:0]   fwd_data;

    assign aph_valid  = ahbls_hready && ahbls_htrans[1];
    assign fifo_push  = dph_wr_q && !fifo_full;
    assign push_entry = '{addr: ENT_ADDR_W'(addr_q), size: size_q, data: ENT_DATA_W'(ahbls_hwdata)};

    ahb_sram_wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AHB_SRAM_WBUF_RAW_FWD_EN
    entry_t            last_q, last_d;
    logic [W_ADDR-1:0] last_addr;
    logic              unused_raw;

    // Youngest pushed entry stays in the FIFO until it empties, so it is valid while non-empty.
    assign last_addr  = W_ADDR'(last_q.addr);
    assign fwd_hit    = dph_rd_q && !fifo_empty && is_full_word(last_q.size)
                        && (last_addr[W_ADDR-1:2] == addr_q[W_ADDR-1:2]);
    assign fwd_data   = W_DATA'(last_q.data);
    assign unused_raw = ^last_addr[1:0];

    always_comb begin
        last_d = last_q;
        if (fifo_push) begin
            last_d = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Upstream dphase tracking and downstream sequencer.
    always_comb begin
        state_d    = state_q;
        dph_wr_d   = dph_wr_q;
        dph_rd_d   = dph_rd_q;
        addr_d     = addr_q;
        size_d     = size_q;
        m_haddr_d  = m_haddr_q;
        m_hwrite_d = m_hwrite_q;
        m_htrans_d = m_htrans_q;
        m_hsize_d  = m_hsize_q;
        m_hwdata_d = m_hwdata_q;
        fifo_pop   = 1'b0;

        if (ahbls_hready) begin
            dph_wr_d = aph_valid && ahbls_hwrite;
            dph_rd_d = aph_valid && !ahbls_hwrite;
            if (aph_valid) begin
                addr_d = ahbls_haddr;
                size_d = ahbls_hsize;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                // Reads only go downstream once every older write has drained.
                if (dph_rd_q && fifo_empty && !fwd_hit) begin
                    state_d    = ST_RD_A;
                    m_haddr_d  = addr_q;
                    m_hsize_d  = size_q;
                    m_hwrite_d = 1'b0;
                    m_htrans_d = HTRANS_NONSEQ;
                end else if (!fifo_empty) begin
                    state_d    = ST_WR_A;
                    m_haddr_d  = W_ADDR'(head.addr);
                    m_hsize_d  = head.size;
                    m_hwrite_d = 1'b1;
                    m_htrans_d = HTRANS_NONSEQ;
                end
            end
            ST_WR_A: begin
                if (ahblm_hready) begin
                    state_d    = ST_WR_D;
                    m_htrans_d = HTRANS_IDLE;
                    m_hwdata_d = W_DATA'(head.data);
                end
            end
            ST_WR_D: begin
                if (ahblm_hready) begin
                    state_d  = ST_IDLE;
                    fifo_pop = 1'b1;
                end
            end
            ST_RD_A: begin
                if (ahblm_hready) begin
                    state_d    = ST_RD_D;
                    m_htrans_d = HTRANS_IDLE;
                end
            end
            ST_RD_D: begin
                if (ahblm_hready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                m_htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // Upstream response: reads complete with the downstream data beat or a forward hit.
    always_comb begin
        ahbls_hready_resp = 1'b1;
        ahbls_hrdata      = '0;
        if (dph_wr_q) begin
            ahbls_hready_resp = !fifo_full;
        end else if (dph_rd_q) begin
            if (fwd_hit) begin
                ahbls_hready_resp = 1'b1;
                ahbls_hrdata      = fwd_data;
            end else begin
                ahbls_hready_resp = (state_q == ST_RD_D) && ahblm_hready;
                ahbls_hrdata      = (state_q == ST_RD_D) ? ahblm_hrdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dph_wr_q   <= 1'b0;
            dph_rd_q   <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            m_haddr_q  <= '0;
            m_hwrite_q <= 1'b0;
            m_htrans_q <= HTRANS_IDLE;
            m_hsize_q  <= '0;
            m_hwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dph_wr_q   <= dph_wr_d;
            dph_rd_q   <= dph_rd_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            m_haddr_q  <= m_haddr_d;
            m_hwrite_q <= m_hwrite_d;
            m_htrans_q <= m_htrans_d;
            m_hsize_q  <= m_hsize_d;
            m_hwdata_q <= m_hwdata_d;
        end
    end

    assign ahbls_hresp     = 1'b0;
    assign ahblm_haddr     = m_haddr_q;
    assign ahblm_hwrite    = m_hwrite_q;
    assign ahblm_htrans    = m_htrans_q;
    assign ahblm_hsize     = m_hsize_q;
    assign ahblm_hwdata    = m_hwdata_q;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

    logic unused;
    assign unused = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0], ahblm_hresp};

endmodule

// File: tb/tb_ahb_sram_wbuf.sv
// Directed bench for ahb_sram_wbuf: single upstream master, simple SRAM-side slave with waits.
module tb_ahb_sram_wbuf;

    logic        clk;
    logic        rst;
    logic        ahbls_hready_resp, ahbls_hready, ahbls_hresp;
    logic [31:0] ahbls_haddr;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize, ahbls_hburst;
    logic [3:0]  ahbls_hprot;
    logic        ahbls_hmastlock;
    logic [31:0] ahbls_hwdata, ahbls_hrdata;
    logic        ahblm_hready, ahblm_hresp;
    logic [31:0] ahblm_haddr;
    logic        ahblm_hwrite;
    logic [1:0]  ahblm_htrans;
    logic [2:0]  ahblm_hsize, ahblm_hburst;
    logic [3:0]  ahblm_hprot;
    logic        ahblm_hmastlock;
    logic [31:0] ahblm_hwdata, ahblm_hrdata;

    int n_checks = 0;
    int n_pass   = 0;

    ahb_sram_wbuf dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_haddr       (ahbls_haddr),
        .ahbls_hwrite      (ahbls_hwrite),
        .ahbls_htrans      (ahbls_htrans),
        .ahbls_hsize       (ahbls_hsize),
        .ahbls_hburst      (ahbls_hburst),
        .ahbls_hprot       (ahbls_hprot),
        .ahbls_hmastlock   (ahbls_hmastlock),
        .ahbls_hwdata      (ahbls_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .ahblm_hready      (ahblm_hready),
        .ahblm_hresp       (ahblm_hresp),
        .ahblm_haddr       (ahblm_haddr),
        .ahblm_hwrite      (ahblm_hwrite),
        .ahblm_htrans      (ahblm_htrans),
        .ahblm_hsize       (ahblm_hsize),
        .ahblm_hburst      (ahblm_hburst),
        .ahblm_hprot       (ahblm_hprot),
        .ahblm_hmastlock   (ahblm_hmastlock),
        .ahblm_hwdata      (ahblm_hwdata),
        .ahblm_hrdata      (ahblm_hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave bus: the bus hready is the buffer's own response.
    assign ahbls_hready = ahbls_hready_resp;
    assign ahblm_hresp  = 1'b0;

    // SRAM-side slave model with optional per-beat waits and a global stall.
    logic        ds_stall;
    int          ds_waits;
    logic        s_dph, s_wr;
    logic [31:0] s_addr;
    int          s_wcnt;
    logic [31:0] smem [256];
    int          wcount = 0;
    logic [31:0] wlog_addr [32];
    logic [31:0] wlog_data [32];

    assign ahblm_hready = !ds_stall && !(s_dph && s_wcnt > 0);
    assign ahblm_hrdata = (s_dph && !s_wr) ? smem[s_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            s_dph        <= 1'b0;
            s_wr         <= 1'b0;
            s_addr       <= 32'h0;
            s_wcnt       <= 0;
            smem[8'hC0]  <= 32'hCAFEF00D;
        end else if (ahblm_hready) begin
            if (s_dph && s_wr) begin
                smem[s_addr[9:2]] <= ahblm_hwdata;
                if (wcount < 32) begin
                    wlog_addr[wcount] <= s_addr;
                    wlog_data[wcount] <= ahblm_hwdata;
                end
                wcount <= wcount + 1;
            end
            s_dph  <= ahblm_htrans[1];
            s_wr   <= ahblm_hwrite;
            s_addr <= ahblm_haddr;
            s_wcnt <= ds_waits;
        end else if (s_dph && s_wcnt > 0) begin
            s_wcnt <= s_wcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Upstream transfer list and per-transfer results.
    logic        sq_wr    [8];
    logic [31:0] sq_addr  [8];
    logic [31:0] sq_wdata [8];
    int          res_cyc  [8];
    logic [31:0] res_rdata[8];

    task automatic set_xfer(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        sq_wr[i]    = wr;
        sq_addr[i]  = addr;
        sq_wdata[i] = wdata;
        res_cyc[i]  = 0;
        res_rdata[i] = 32'h0;
    endtask

    // Issues n pipelined transfers; downstream is stalled for the first stall_cycles cycles.
    task automatic ahb_run(input int n, input int stall_cycles);
        int ia = 0;
        int di = -1;
        int dc = 0;
        int cyc = 0;
        while ((ia < n || di >= 0) && cyc < 200) begin
            @(posedge clk);
            #1;
            ds_stall = (cyc < stall_cycles);
            if (ia < n) begin
                ahbls_htrans = 2'b10;
                ahbls_haddr  = sq_addr[ia];
                ahbls_hwrite = sq_wr[ia];
            end else begin
                ahbls_htrans = 2'b00;
                ahbls_hwrite = 1'b0;
            end
            ahbls_hwdata = (di >= 0 && sq_wr[di]) ? sq_wdata[di] : 32'h0;
            #4;
            if (di >= 0) begin
                dc++;
                if (ahbls_hready_resp) begin
                    res_cyc[di]   = dc;
                    res_rdata[di] = ahbls_hrdata;
                    di = -1;
                end
            end
            if (ahbls_hready_resp && ia < n) begin
                di = ia;
                ia++;
                dc = 0;
            end
            cyc++;
        end
        check("run_done", 64'(ia == n && di < 0), 64'd1);
        @(posedge clk);
        #1;
        ahbls_htrans = 2'b00;
        ahbls_hwdata = 32'h0;
        ds_stall     = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int n);
        int t = 0;
        while (wcount < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, 64'(wcount), 64'(n));
        repeat (2) @(posedge clk);
    endtask

    int wb;

    initial begin
        rst             = 1'b1;
        ds_stall        = 1'b0;
        ds_waits        = 0;
        ahbls_haddr     = 32'h0;
        ahbls_hwrite    = 1'b0;
        ahbls_htrans    = 2'b00;
        ahbls_hsize     = 3'd2;
        ahbls_hburst    = 3'd0;
        ahbls_hprot     = 4'b0011;
        ahbls_hmastlock = 1'b0;
        ahbls_hwdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check("rst_hready_resp", 64'(ahbls_hready_resp), 64'd1);
        check("rst_hresp",       64'(ahbls_hresp),       64'd0);
        check("rst_htrans",      64'(ahblm_htrans),      64'd0);
        check("rst_hrdata",      64'(ahbls_hrdata),      64'd0);
        check("rst_haddr",       64'(ahblm_haddr),       64'd0);
        check("rst_hwdata",      64'(ahblm_hwdata),      64'd0);
        check("rst_hwrite",      64'(ahblm_hwrite),      64'd0);

        // Two posted writes, zero-wait downstream.
        wb = wcount;
        set_xfer(0, 1'b1, 32'h100, 32'hDEADBEEF);
        set_xfer(1, 1'b1, 32'h104, 32'h12345678);
        ahb_run(2, 0);
        check("b2b_w0_cyc", 64'(res_cyc[0]), 64'd1);
        check("b2b_w1_cyc", 64'(res_cyc[1]), 64'd1);
        wait_drain("b2b_drain", wb + 2);
        check("b2b_w0_addr", 64'(wlog_addr[wb]),     64'h100);
        check("b2b_w0_data", 64'(wlog_data[wb]),     64'hDEADBEEF);
        check("b2b_w1_addr", 64'(wlog_addr[wb + 1]), 64'h104);
        check("b2b_w1_data", 64'(wlog_data[wb + 1]), 64'h12345678);
        check("hresp_zero",  64'(ahbls_hresp),       64'd0);

        // Three writes with downstream stalled 4 cycles: third waits for the first drain.
        wb = wcount;
        set_xfer(0, 1'b1, 32'h110, 32'h11111111);
        set_xfer(1, 1'b1, 32'h114, 32'h22222222);
        set_xfer(2, 1'b1, 32'h118, 32'h33333333);
        ahb_run(3, 4);
        check("full_w0_cyc", 64'(res_cyc[0]), 64'd1);
        check("full_w1_cyc", 64'(res_cyc[1]), 64'd1);
        check("full_w2_cyc", 64'(res_cyc[2]), 64'd4);
        wait_drain("full_drain", wb + 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full_w%0d_addr", i), 64'(wlog_addr[wb + i]), 64'(32'h110 + 32'(4 * i)));
            check($sformatf("full_w%0d_data", i), 64'(wlog_data[wb + i]), 64'(32'h11111111 * 32'(i + 1)));
        end

        // Read from empty buffer: one downstream wait, then zero wait.
        ds_waits = 1;
        set_xfer(0, 1'b0, 32'h300, 32'h0);
        ahb_run(1, 0);
        check("rd1w_data", 64'(res_rdata[0]), 64'hCAFEF00D);
        check("rd1w_cyc",  64'(res_cyc[0]),   64'd4);
        ds_waits = 0;
        set_xfer(0, 1'b0, 32'h300, 32'h0);
        ahb_run(1, 0);
        check("rd0w_data", 64'(res_rdata[0]), 64'hCAFEF00D);
        check("rd0w_cyc",  64'(res_cyc[0]),   64'd3);

        // Read-after-write to the same word.
        wb = wcount;
        set_xfer(0, 1'b1, 32'h200, 32'hA5A5A5A5);
        set_xfer(1, 1'b0, 32'h200, 32'h0);
        ahb_run(2, 0);
        check("raw_w_cyc",  64'(res_cyc[0]),   64'd1);
        check("raw_r_data", 64'(res_rdata[1]), 64'hA5A5A5A5);
`ifdef AHB_SRAM_WBUF_RAW_FWD_EN
        check("raw_r_cyc_fwd", 64'(res_cyc[1]), 64'd1);
`else
        check("raw_r_waited", 64'(res_cyc[1] > 3), 64'd1);
`endif
        wait_drain("raw_drain", wb + 1);
        check("raw_w_addr", 64'(wlog_addr[wb]), 64'h200);
        check("raw_w_data", 64'(wlog_data[wb]), 64'hA5A5A5A5);

        // Reset while a write beat is stalled in its data phase with two entries buffered.
        wb = wcount;
        ds_waits = 5;
        set_xfer(0, 1'b1, 32'h400, 32'h44444444);
        set_xfer(1, 1'b1, 32'h404, 32'h55555555);
        ahb_run(2, 0);
        begin
            int t = 0;
            while (!(s_dph && s_wr && !ahblm_hready) && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("rstmid_in_wrd", 64'(s_dph && s_wr && !ahblm_hready), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ds_waits = 0;
        #3;
        check("rstmid_htrans",      64'(ahblm_htrans),      64'd0);
        check("rstmid_hready_resp", 64'(ahbls_hready_resp), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("rstmid_no_drain", 64'(wcount),       64'(wb));
        check("rstmid_idle",     64'(ahblm_htrans), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
